bcd_multi_counter: RTL
======================

Name: bcd_multi_counter

Overview:
- Parametrised N-digit packed-BCD up/down counter with runtime min/max wrap limits, synchronous load and enable.
- Replaces chains of single-digit BCD counters in the clock/date/stopwatch datapaths, e.g. seconds 00-59, hours 00-23, day 01-31.
- Provides a combinational terminal-count flag and a registered wrap pulse for cascading into the next field.

Parameters:
- DIGITS, 2, number of BCD digits; value width W = 4*DIGITS.
- INIT, 0 (W bits), packed-BCD value loaded by reset and by `clr`.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset; cnt <= INIT, wrap <= 0.
- clr  input  1  synchronous clear to INIT; does not require `en`.
- load  input  1  synchronous load of `load_val`.
- load_val  input  W  packed-BCD load value.
- en  input  1  count enable; 0 = hold (stop).
- dn  input  1  direction: 0 = up, 1 = down.
- max  input  W  packed-BCD upper limit.
- min  input  W  packed-BCD lower limit, min <= max numerically.
- cnt  output  W  current packed-BCD count.
- tc  output  1  combinational terminal count.
- wrap  output  1  registered one-cycle pulse, high the cycle after a wrap.

Behaviour:
- Reset: rst=1 at a clock edge -> cnt=INIT, wrap=0. No asynchronous path; rst high mid-count takes effect at the next edge.
- Priority per edge: rst > clr > load > en=0 (hold) > count.
- clr: cnt <= INIT, wrap <= 0.
- load: each 4-bit digit of load_val > 9 is clamped to 9 before storing; wrap <= 0.
- Hold (en=0): cnt unchanged, wrap <= 0.
- tc, combinational:
  - tc = (cnt == max) when dn=0.
  - tc = (cnt == min) when dn=1.
  - Independent of en; usable as the enable for the next counter.
- Count up (en=1, dn=0):
  - tc=1: cnt <= min, wrap <= 1.
  - Otherwise cnt <= cnt + 1 in BCD. Digit i increments when all lower digits are 9; lower digits that are 9 go to 0.
  - All-9s with max above it cannot occur. If cnt > max (e.g. after a load), counting continues upward. At 99..9 it rolls to 00..0 with wrap <= 0, because only a tc-wrap sets wrap.
- Count down (en=1, dn=1):
  - tc=1: cnt <= max, wrap <= 1.
  - Otherwise cnt <= cnt - 1 in BCD. Digit i decrements when all lower digits are 0; lower 0 digits go to 9.
  - At 00..0 with cnt < min: rolls to 99..9 with wrap <= 0.
- Direction change: takes effect on the same edge; tc recomputes immediately from the new dn.
- min == max with en=1: cnt held at min and wrap=1 every enabled cycle.
- Limit changes: max/min are sampled every cycle; changing them mid-count only affects tc/wrap from that cycle on.
- Latency: cnt updates one cycle after the enabling edge. wrap asserts in the cycle following the wrapping edge and lasts exactly one cycle unless another wrap follows.
- cnt never holds a non-BCD digit if INIT is BCD.

Test Plan:
- Reset and seconds up-count. DIGITS=2, INIT=8'h00, min=00, max=59, dn=0, en=1. Deassert rst and count 60 edges:
  - cnt steps 00,01..09,10..59,00.
  - tc=1 only while cnt=59.
  - wrap=1 for exactly one cycle after the 59->00 edge.
- Down-count with borrow. load_val=8'h10, load=1, then en=1, dn=1, min=01, max=31:
  - cnt goes 10->09->...->01->31.
  - wrap pulses once after 01->31.
  - tc=1 while cnt=01.
- Priority and hold:
  - At cnt=8'h23, assert en=0 for 3 cycles -> cnt stays 23, wrap=0.
  - Assert load=1 (load_val=8'h45) and clr=1 together -> cnt=INIT.
  - Assert rst with clr, load, en all high -> cnt=INIT, wrap=0.
- Load clamp and out-of-range:
  - load_val=8'hAC -> cnt=8'h99.
  - Then up with max=59 -> cnt 99->00 with wrap=0, then 01.
- Cascade, DIGITS=2 x 2 instances (minutes and hours):
  - Second instance en driven by the first's tc & en. Run 00:59 -> 01:00.
  - At 23:59 with hours max=23 -> 00:00.
  - Both wrap outputs pulse on the same cycle.
- Mid-count reset and direction flip:
  - At cnt=37, flip dn=1 -> next 36.
  - At cnt=37, assert rst for one edge -> next cnt=INIT, and counting resumes from INIT the following edge.

Source files
------------

// File: rtl/bcd_multi_counter.sv
// ---------------------------------------------------------------------------
// bcd_multi_counter
//
// Purpose:
//   N-digit packed-BCD up/down counter that wraps between runtime limits
//   min_i and max_i. Used for clock, date and stopwatch fields such as
//   seconds 00-59, hours 00-23 and day 01-31. Several instances can be
//   cascaded: tc_o of one field enables the next field, and wrap_o marks
//   the cycle after a field wrapped.
//
// Ports:
//   clk_i       system clock; all state changes on the rising edge
//   rst_i       synchronous active-high reset (cnt_o <= INIT, wrap_o <= 0)
//   clr_i       synchronous clear to INIT; works without en_i
//   load_i      synchronous load of load_val_i (each digit clamped to 9)
//   load_val_i  packed-BCD load value, W bits
//   en_i        count enable; 0 holds the count
//   dn_i        direction: 0 = up, 1 = down
//   max_i       packed-BCD upper limit, W bits
//   min_i       packed-BCD lower limit, W bits (min_i <= max_i)
//   cnt_o       current packed-BCD count, W bits
//   tc_o        combinational terminal count for the current direction
//   wrap_o      registered one-cycle pulse after a limit wrap
//
// Priority on each edge: rst > clr > load > hold (en=0) > count.
// ---------------------------------------------------------------------------
module bcd_multi_counter #(
   parameter int                    DIGITS = 2,
   parameter logic [4*DIGITS-1:0]   INIT   = '0
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  clr_i,
   input  logic                  load_i,
   input  logic [4*DIGITS-1:0]   load_val_i,
   input  logic                  en_i,
   input  logic                  dn_i,
   input  logic [4*DIGITS-1:0]   max_i,
   input  logic [4*DIGITS-1:0]   min_i,
   output logic [4*DIGITS-1:0]   cnt_o,
   output logic                  tc_o,
   output logic                  wrap_o
);

   localparam int W = 4 * DIGITS;

   logic [W-1:0]        cnt_q;
   logic [W-1:0]        cnt_d;
   logic                wrap_q;
   logic                wrap_d;

   logic [W-1:0]        inc_val;
   logic [W-1:0]        dec_val;
   logic [W-1:0]        clamp_val;

   // all9_below[i] : every digit below digit i is 9 (carry into digit i)
   // all0_below[i] : every digit below digit i is 0 (borrow into digit i)
   logic [DIGITS-1:0]   all9_below;
   logic [DIGITS-1:0]   all0_below;

   assign all9_below[0] = 1'b1;
   assign all0_below[0] = 1'b1;

   generate
      for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
         logic [3:0] dig;
         logic [3:0] lv_dig;

         assign dig    = cnt_q[4*gi +: 4];
         assign lv_dig = load_val_i[4*gi +: 4];

         if (gi < DIGITS - 1) begin : g_chain
            assign all9_below[gi+1] = all9_below[gi] & (dig == 4'd9);
            assign all0_below[gi+1] = all0_below[gi] & (dig == 4'd0);
         end

         // BCD increment: a digit only moves when every lower digit carries
         assign inc_val[4*gi +: 4] = !all9_below[gi] ? dig :
                                     (dig == 4'd9)   ? 4'd0 : 4'(dig + 4'd1);

         // BCD decrement: a digit only moves when every lower digit borrows
         assign dec_val[4*gi +: 4] = !all0_below[gi] ? dig :
                                     (dig == 4'd0)   ? 4'd9 : 4'(dig - 4'd1);

         // Non-BCD load digits are clamped so the count stays valid BCD
         assign clamp_val[4*gi +: 4] = (lv_dig > 4'd9) ? 4'd9 : lv_dig;
      end
   endgenerate

   // Terminal count follows the live direction, independent of enable
   assign tc_o = dn_i ? (cnt_q == min_i) : (cnt_q == max_i);

   always_comb begin
      cnt_d  = cnt_q;
      wrap_d = 1'b0;
      if (clr_i) begin
         cnt_d = INIT;
      end else if (load_i) begin
         cnt_d = clamp_val;
      end else if (en_i) begin
         if (tc_o) begin
            // Limit wrap: the only path that raises wrap
            cnt_d  = dn_i ? max_i : min_i;
            wrap_d = 1'b1;
         end else begin
            // Out-of-range counts simply keep going and roll over 99..9/00..0
            cnt_d = dn_i ? dec_val : inc_val;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q  <= INIT;
         wrap_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         wrap_q <= wrap_d;
      end
   end

   assign cnt_o  = cnt_q;
   assign wrap_o = wrap_q;

endmodule
